topk_tracker: RTL and testbench
===============================

// Module: topk_tracker
// PURPOSE
//   Streaming rank tracker. Keeps the K most extreme values (largest or smallest)
//   accepted since the last reset or clear, held as a sorted register list. Reports
//   the value at a runtime-selected rank; rank 1 of a K=2 max tracker gives the
//   second-largest value. Sits on sample streams feeding statistics and threshold logic.
// PARAMETERS
//   DATA_WIDTH  32  width of the unsigned sample
//   K           4   list depth, i.e. the number of ranks tracked; K >= 2
//   MODE        0   0 = track largest (MODE_MAX); 1 = track smallest (MODE_MIN)
// PORTS
//   clk        in   1                  single clock, rising edge
//   resetn     in   1                  asynchronous, active-low reset
//   clear      in   1                  synchronous restart of the list
//   din_valid  in   1                  din is a sample this cycle
//   din        in   DATA_WIDTH         unsigned sample
//   rank_sel   in   $clog2(K)          rank queried; 0 = most extreme value
//   dout       out  DATA_WIDTH         value at rank_sel; 0 when that rank is empty
//   dout_valid out  1                  the rank_sel entry is occupied
//   count      out  $clog2(K+1)        occupied entries; saturates at K
//   full       out  1                  count == K
// BEHAVIOUR
// - State: entry[0..K-1] data plus occ[0..K-1] occupancy bits.
//   - Sorted with entry[0] the most extreme; occupied entries are contiguous from 0.
// - Reset (resetn low, asynchronous): all occ=0, entries=0, dout=0, dout_valid=0,
//   count=0, full=0. The same values hold while resetn stays low.
// - "beats(x,e)":
//   - MODE_MAX: x > e. MODE_MIN: x < e.
//   - An unoccupied slot is always beaten.
// - Insert, on an edge where din_valid=1:
//   - p = lowest index i where beats(din, entry[i]).
//   - entry[p] <= din; entries p..K-2 shift down one slot; entry[K-1] is dropped.
//   - If no p exists, the list is unchanged; the sample is discarded.
// - Duplicates are separate candidates.
//   - An equal value does not beat an existing entry, so it inserts after it.
//   - Example (max): 9 then 9 gives ranks 0 and 1 both equal to 9.
// - clear=1:
//   - The list empties on that edge.
//   - If din_valid is also 1, din is inserted into the emptied list (count=1).
//   - clear has priority over any insert into the old contents.
// - Latency:
//   - dout, dout_valid, count and full are registered from next-state.
//   - A sample accepted at edge N is reflected in the outputs after edge N.
//   - rank_sel is sampled at the same edge.
// - dout = occ'[rank_sel] ? entry'[rank_sel] : 0, where ' denotes next-state.
//   dout_valid = occ'[rank_sel].
// - rank_sel >= K (non-power-of-two K): dout=0, dout_valid=0.
// - count increments on an accepted insert while count < K, then holds at K.
// - din_valid=0 and clear=0: all state holds; outputs still track rank_sel changes.
// - Width: comparisons are unsigned and DATA_WIDTH-wide only; no arithmetic.
// STRUCTURE
// - Package topk_pkg:
//   - mode_e {MODE_MAX=0, MODE_MIN=1}.
//   - Function beats(x, e, occ, mode).
// - Sub-module topk_slot, one per list index, instantiated by generate.
//   - Inputs: own entry/occ, the upper neighbour's entry/occ, beats_here, beats_above.
//   - Next-state: beats_above ? neighbour : beats_here ? din : hold.
//   - Handles clear. The top slot's neighbour is tied off as "not beaten".
// - Top level: beats vector, count/full logic, rank mux, output registers.
// TESTING (DATA_WIDTH=8, K=4, MODE_MAX unless stated)
// 1. Reset, then din 5 -> rank0=5, rank1 dout=0 dout_valid=0, count=1.
// 2. Stream 3,7,7,1,9 -> list 9,7,7,3; count=4, full=1. Then din 2 -> list unchanged.
// 3. Duplicates 4,4 with rank_sel=1 -> dout=4, dout_valid=1 after the second edge.
// 4. Full list 9,7,7,3; clear+din_valid din=6 -> count=1, rank0=6, rank1 empty.
//    Then clear alone -> count=0.
// 5. Assert resetn low mid-stream, asynchronously between edges -> outputs are 0
//    immediately. After release, din 8 -> rank0=8, count=1.
// 6. MODE_MIN, stream 5,2,8,2 -> list 2,2,5,8; rank_sel sweep 0..3 gives 2,2,5,8.

Source files
------------

// File: rtl/topk_pkg.sv
// Shared types and the ordering predicate for the streaming top-K tracker.
package topk_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } mode_e;

  localparam int unsigned MaxDataWidth = 64;
  typedef logic [MaxDataWidth-1:0] cmp_t;

  // Callers zero-extend to cmp_t, so the unsigned order of the original width is preserved.
  function automatic logic beats(cmp_t x, cmp_t e, logic occ, mode_e mode);
    if (!occ) begin
      return 1'b1;
    end
    return (mode == MODE_MAX) ? (x > e) : (x < e);
  endfunction

endpackage

// File: rtl/topk_slot.sv
// One position of the sorted list: takes the upper neighbour, the new sample, or holds.
module topk_slot #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  beats_here_i,
  input  logic                  beats_above_i,
  input  logic [DATA_WIDTH-1:0] nb_entry_i,
  input  logic                  nb_occ_i,
  output logic [DATA_WIDTH-1:0] entry_o,
  output logic                  occ_o,
  output logic [DATA_WIDTH-1:0] entry_d_o,
  output logic                  occ_d_o
);

  logic [DATA_WIDTH-1:0] entry_q, entry_d;
  logic                  occ_q, occ_d;

  always_comb begin
    entry_d = entry_q;
    occ_d   = occ_q;
    if (beats_above_i) begin
      // On clear the neighbour's old contents are gone, so only its data shifts in.
      entry_d = nb_entry_i;
      occ_d   = nb_occ_i & ~clear_i;
    end else if (beats_here_i) begin
      entry_d = din_i;
      occ_d   = 1'b1;
    end else if (clear_i) begin
      entry_d = '0;
      occ_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry_q <= '0;
      occ_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      occ_q   <= occ_d;
    end
  end

  assign entry_o   = entry_q;
  assign occ_o     = occ_q;
  assign entry_d_o = entry_d;
  assign occ_d_o   = occ_d;

endmodule

// File: rtl/topk_tracker.sv
// Streaming rank tracker: keeps the K most extreme samples sorted and reports one by rank.
module topk_tracker import topk_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned K          = 4,
  parameter int unsigned MODE       = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   din_valid,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic [$clog2(K)-1:0]   rank_sel,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic [$clog2(K+1)-1:0] count,
  output logic                   full
);

  localparam int unsigned CountW = $clog2(K + 1);
  localparam mode_e       Mode   = (MODE == 0) ? MODE_MAX : MODE_MIN;

  logic [DATA_WIDTH-1:0] entry_q  [K];
  logic [DATA_WIDTH-1:0] entry_d  [K];
  logic [DATA_WIDTH-1:0] nb_entry [K];
  logic [K-1:0]          occ_q, occ_d, nb_occ, live, beats_vec, above;
  logic                  accept;

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [CountW-1:0]     count_q, count_d;
  logic                  full_q, full_d;

  always_comb begin
    live     = occ_q & ~{K{clear}};
    above    = '0;
    nb_occ   = '0;
    nb_entry = '{default: '0};
    for (int i = 0; i < K; i++) begin
      beats_vec[i] = din_valid & beats(cmp_t'(din), cmp_t'(entry_q[i]), live[i], Mode);
    end
    // Slot 0 has no neighbour above; it is never "beaten from above".
    for (int i = 1; i < K; i++) begin
      above[i]    = above[i-1] | beats_vec[i-1];
      nb_entry[i] = entry_q[i-1];
      nb_occ[i]   = occ_q[i-1];
    end
    accept = |beats_vec;
  end

  for (genvar g = 0; g < K; g++) begin : gen_slot
    topk_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk          (clk),
      .resetn       (resetn),
      .clear_i      (clear),
      .din_i        (din),
      .beats_here_i (beats_vec[g]),
      .beats_above_i(above[g]),
      .nb_entry_i   (nb_entry[g]),
      .nb_occ_i     (nb_occ[g]),
      .entry_o      (entry_q[g]),
      .occ_o        (occ_q[g]),
      .entry_d_o    (entry_d[g]),
      .occ_d_o      (occ_d[g])
    );
  end

  always_comb begin
    if (clear) begin
      count_d = CountW'(din_valid);
    end else if (accept && (count_q != CountW'(K))) begin
      count_d = count_q + CountW'(1);
    end else begin
      count_d = count_q;
    end
    full_d = (count_d == CountW'(K));

    dout_d       = '0;
    dout_valid_d = 1'b0;
    if ((32'(rank_sel) < K) && occ_d[rank_sel]) begin
      dout_d       = entry_d[rank_sel];
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      count_q      <= '0;
      full_q       <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      count_q      <= count_d;
      full_q       <= full_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign full       = full_q;

endmodule

// File: tb/tb_topk_tracker.sv
// Table-driven scoreboard bench for topk_tracker (8-bit, K=4, max and min instances).
module tb_topk_tracker;

  typedef struct {
    logic       clr;
    logic       vld;
    logic [7:0] din;
    logic [1:0] rs;
    logic [7:0] e_dout;
    logic       e_valid;
    logic [2:0] e_count;
    logic       e_full;
  } vec_t;

  logic       clk, resetn, clear, din_valid;
  logic [7:0] din;
  logic [1:0] rank_sel;
  logic [7:0] dout_max, dout_min;
  logic       dv_max, dv_min, full_max, full_min;
  logic [2:0] cnt_max, cnt_min;
  logic       use_min;

  int total = 0;
  int bad   = 0;
  int step  = 0;
  vec_t vecs[$];
  vec_t sb[$];

  topk_tracker #(.DATA_WIDTH(8), .K(4), .MODE(0)) u_max (
    .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din),
    .rank_sel(rank_sel), .dout(dout_max), .dout_valid(dv_max), .count(cnt_max), .full(full_max)
  );

  topk_tracker #(.DATA_WIDTH(8), .K(4), .MODE(1)) u_min (
    .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din),
    .rank_sel(rank_sel), .dout(dout_min), .dout_valid(dv_min), .count(cnt_min), .full(full_min)
  );

  wire [7:0] a_dout  = use_min ? dout_min : dout_max;
  wire       a_valid = use_min ? dv_min : dv_max;
  wire [2:0] a_count = use_min ? cnt_min : cnt_max;
  wire       a_full  = use_min ? full_min : full_max;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic c, logic v, logic [7:0] d, logic [1:0] r,
                              logic [7:0] ed, logic ev, logic [2:0] ec, logic ef);
    vec_t t;
    t.clr = c; t.vld = v; t.din = d; t.rs = r;
    t.e_dout = ed; t.e_valid = ev; t.e_count = ec; t.e_full = ef;
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d: got %0d expected %0d", nm, step, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_dout"}, 32'(a_dout), 0);
    cmp({tag, "_valid"}, 32'(a_valid), 0);
    cmp({tag, "_count"}, 32'(a_count), 0);
    cmp({tag, "_full"}, 32'(a_full), 0);
  endtask

  task automatic check_out();
    vec_t e;
    if (sb.size() == 0) begin
      cmp("sb_underflow", 1, 0);
      return;
    end
    e = sb.pop_front();
    cmp("dout", 32'(a_dout), 32'(e.e_dout));
    cmp("dout_valid", 32'(a_valid), 32'(e.e_valid));
    cmp("count", 32'(a_count), 32'(e.e_count));
    cmp("full", 32'(a_full), 32'(e.e_full));
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    clear     = v.clr;
    din_valid = v.vld;
    din       = v.din;
    rank_sel  = v.rs;
    sb.push_back(v);
    @(posedge clk);
    #1;
    step++;
    check_out();
  endtask

  task automatic go_idle();
    clear = 1'b0; din_valid = 1'b0; din = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    use_min = 1'b0;
    resetn  = 1'b0;
    go_idle();
    rank_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    resetn = 1'b1;

    //        clr vld din rs   dout vld cnt full
    vecs.push_back(mk(0, 1, 5,   0, 5,   1, 1, 0));
    vecs.push_back(mk(0, 0, 0,   1, 0,   0, 1, 0));
    vecs.push_back(mk(1, 0, 0,   0, 0,   0, 0, 0));
    vecs.push_back(mk(0, 1, 3,   0, 3,   1, 1, 0));
    vecs.push_back(mk(0, 1, 7,   0, 7,   1, 2, 0));
    vecs.push_back(mk(0, 1, 7,   1, 7,   1, 3, 0));
    vecs.push_back(mk(0, 1, 1,   3, 1,   1, 4, 1));
    vecs.push_back(mk(0, 1, 9,   0, 9,   1, 4, 1));
    vecs.push_back(mk(0, 1, 2,   3, 3,   1, 4, 1));
    vecs.push_back(mk(0, 0, 0,   1, 7,   1, 4, 1));
    vecs.push_back(mk(0, 0, 0,   2, 7,   1, 4, 1));
    vecs.push_back(mk(1, 1, 6,   0, 6,   1, 1, 0));
    vecs.push_back(mk(0, 0, 0,   1, 0,   0, 1, 0));
    vecs.push_back(mk(1, 0, 0,   0, 0,   0, 0, 0));
    vecs.push_back(mk(0, 1, 4,   1, 0,   0, 1, 0));
    vecs.push_back(mk(0, 1, 4,   1, 4,   1, 2, 0));
    vecs.push_back(mk(0, 1, 9,   0, 9,   1, 3, 0));
    vecs.push_back(mk(0, 1, 3,   3, 3,   1, 4, 1));
    vecs.push_back(mk(0, 1, 5,   3, 4,   1, 4, 1));
    vecs.push_back(mk(0, 0, 0,   1, 5,   1, 4, 1));
    vecs.push_back(mk(0, 1, 4,   3, 4,   1, 4, 1));
    vecs.push_back(mk(0, 1, 255, 0, 255, 1, 4, 1));
    vecs.push_back(mk(0, 1, 0,   3, 4,   1, 4, 1));
    vecs.push_back(mk(0, 0, 0,   2, 5,   1, 4, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
    end

    // Asynchronous reset asserted between edges on a full list.
    @(posedge clk);
    #3;
    go_idle();
    resetn = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    check_zero("async_rst_hold");
    @(negedge clk);
    resetn = 1'b1;
    drive(mk(0, 1, 8, 0, 8, 1, 1, 0));
    drive(mk(0, 0, 0, 1, 0, 0, 1, 0));

    // Min-tracking instance from a fresh reset.
    @(negedge clk);
    go_idle();
    use_min = 1'b1;
    resetn  = 1'b0;
    #1;
    check_zero("min_rst");
    @(negedge clk);
    resetn = 1'b1;
    drive(mk(0, 1, 5, 0, 5, 1, 1, 0));
    drive(mk(0, 1, 2, 0, 2, 1, 2, 0));
    drive(mk(0, 1, 8, 2, 8, 1, 3, 0));
    drive(mk(0, 1, 2, 1, 2, 1, 4, 1));
    drive(mk(0, 0, 0, 0, 2, 1, 4, 1));
    drive(mk(0, 0, 0, 1, 2, 1, 4, 1));
    drive(mk(0, 0, 0, 2, 5, 1, 4, 1));
    drive(mk(0, 0, 0, 3, 8, 1, 4, 1));
    drive(mk(0, 1, 9, 3, 8, 1, 4, 1));

    cmp("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
